// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select codes,
// M-stage load-type encoding and the mult/div sequencer state encoding.
package hazard_ctrl_pkg;

    localparam logic [2:0] FWD_REG   = 3'd0;
    localparam logic [2:0] FWD_ALUE  = 3'd1;
    localparam logic [2:0] FWD_ALUM  = 3'd2;
    localparam logic [2:0] FWD_WORDM = 3'd3;
    localparam logic [2:0] FWD_HALFM = 3'd4;
    localparam logic [2:0] FWD_BYTEM = 3'd5;
    localparam logic [2:0] FWD_HILOW = 3'd6;
    localparam logic [2:0] FWD_HILOM = 3'd7;

    typedef enum logic [1:0] {
        LOAD_ALU  = 2'd0,
        LOAD_WORD = 2'd1,
        LOAD_HALF = 2'd2,
        LOAD_BYTE = 2'd3
    } loadType_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } muldivState_e;

    // True when a later stage is writing the nonzero register a D-stage operand reads.
    function automatic logic regMatch(input logic [4:0] src,
                                      input logic [4:0] dst,
                                      input logic       we);
        return we && (src != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select for the decode-stage bypass muxes.
// Priority is E over M over W over the register file.
module hazard_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] regD,
    input  logic       useD,
    input  logic [4:0] writeRegE,
    input  logic       regWriteE,
    input  logic       loadE,
    input  logic       hiloReadE,
    input  logic [4:0] writeRegM,
    input  logic       regWriteM,
    input  logic [1:0] loadTypeM,
    input  logic       hiloReadM,
    input  logic [4:0] writeRegW,
    input  logic       regWriteW,
    input  logic       hiloReadW,
    output logic [2:0] fwdSel
);

    // Pick the youngest in-flight producer; loads and mfhi/mflo in E cannot forward yet.
    always_comb begin
        fwdSel = FWD_REG;
        if (!useD || (regD == 5'd0)) begin
            fwdSel = FWD_REG;
        end else if (regMatch(regD, writeRegE, regWriteE) && !loadE && !hiloReadE) begin
            fwdSel = FWD_ALUE;
        end else if (regMatch(regD, writeRegM, regWriteM)) begin
            if (hiloReadM) begin
                fwdSel = FWD_HILOM;
            end else begin
                case (loadType_e'(loadTypeM))
                    LOAD_BYTE: fwdSel = FWD_BYTEM;
                    LOAD_HALF: fwdSel = FWD_HALFM;
                    LOAD_WORD: fwdSel = FWD_WORDM;
                    default:   fwdSel = FWD_ALUM;
                endcase
            end
        end else if (regMatch(regD, writeRegW, regWriteW) && hiloReadW) begin
            fwdSel = FWD_HILOW;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use stalls and
// HI/LO mult/div sequencing. Define HAZ_MULDIV_ITER_EN to build the iterative
// mult/div sequencer; otherwise mult/div are treated as single-cycle.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       useRsD,
    input  logic       useRtD,
    input  logic [4:0] writeRegE,
    input  logic       regWriteE,
    input  logic       loadE,
    input  logic       hiloReadE,
    input  logic [4:0] writeRegM,
    input  logic       regWriteM,
    input  logic [1:0] loadTypeM,
    input  logic       hiloReadM,
    input  logic [4:0] writeRegW,
    input  logic       regWriteW,
    input  logic       hiloReadW,
    input  logic       multD,
    input  logic       divD,
    input  logic       hiloReadD,
    output logic [2:0] forwardAD,
    output logic [2:0] forwardBD,
    output logic       stallF,
    output logic       stallD,
    output logic       flushE,
    output logic       muldivStartE,
    output logic       hiloWe,
    output logic       muldivBusy
);

    logic [2:0] fwdARaw;
    logic [2:0] fwdBRaw;
    logic       rsHitE;
    logic       rtHitE;
    logic       loadUse;
    logic       busyStall;
    logic       stallRaw;
    logic       launch;
    logic       hiloWeRaw;
    logic       busyRaw;

    hazard_fwd_sel fwdSelA (
        .regD      (rsD),
        .useD      (useRsD),
        .writeRegE (writeRegE),
        .regWriteE (regWriteE),
        .loadE     (loadE),
        .hiloReadE (hiloReadE),
        .writeRegM (writeRegM),
        .regWriteM (regWriteM),
        .loadTypeM (loadTypeM),
        .hiloReadM (hiloReadM),
        .writeRegW (writeRegW),
        .regWriteW (regWriteW),
        .hiloReadW (hiloReadW),
        .fwdSel    (fwdARaw)
    );

    hazard_fwd_sel fwdSelB (
        .regD      (rtD),
        .useD      (useRtD),
        .writeRegE (writeRegE),
        .regWriteE (regWriteE),
        .loadE     (loadE),
        .hiloReadE (hiloReadE),
        .writeRegM (writeRegM),
        .regWriteM (regWriteM),
        .loadTypeM (loadTypeM),
        .hiloReadM (hiloReadM),
        .writeRegW (writeRegW),
        .regWriteW (regWriteW),
        .hiloReadW (hiloReadW),
        .fwdSel    (fwdBRaw)
    );

    // A load or mfhi/mflo in E has no value to bypass yet, so a dependent D must wait.
    assign rsHitE   = useRsD && regMatch(rsD, writeRegE, regWriteE);
    assign rtHitE   = useRtD && regMatch(rtD, writeRegE, regWriteE);
    assign loadUse  = (loadE || hiloReadE) && (rsHitE || rtHitE);
    assign stallRaw = loadUse || busyStall;

`ifdef HAZ_MULDIV_ITER_EN
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    muldivState_e     state_q;
    muldivState_e     state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Sequencer state and countdown; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Load the countdown at launch, count to zero, then spend one cycle writing HI/LO.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_BUSY;
                    count_d = divD ? DIV_LOAD : MULT_LOAD;
                end
            end
            ST_BUSY: begin
                if (count_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Decode the sequencer state into busy, busy-stall, write-back and launch controls.
    always_comb begin
        busyRaw   = (state_q != ST_IDLE);
        busyStall = busyRaw && (hiloReadD || multD || divD);
        hiloWeRaw = (state_q == ST_DONE);
        launch    = (state_q == ST_IDLE) && (multD || divD) && !(loadUse || busyStall);
    end
`else
    logic startE_q;
    logic unusedHiloReadD;

    assign unusedHiloReadD = hiloReadD;
    assign busyRaw         = 1'b0;
    assign busyStall       = 1'b0;
    assign launch          = (multD || divD) && !stallRaw;
    assign hiloWeRaw       = startE_q;

    // Single-cycle mult/div: HI/LO is written the cycle after the launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            startE_q <= 1'b0;
        end else begin
            startE_q <= launch;
        end
    end
`endif

    // Every output is held low while reset is asserted.
    assign forwardAD    = rst ? FWD_REG : fwdARaw;
    assign forwardBD    = rst ? FWD_REG : fwdBRaw;
    assign stallF       = !rst && stallRaw;
    assign stallD       = !rst && stallRaw;
    assign flushE       = !rst && stallRaw;
    assign muldivStartE = !rst && launch;
    assign hiloWe       = !rst && hiloWeRaw;
    assign muldivBusy   = !rst && busyRaw;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: forwarding priority, load-use stalls,
// mult/div sequencing and reset. Follows HAZ_MULDIV_ITER_EN like the design.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic       useRsD;
    logic       useRtD;
    logic [4:0] writeRegE;
    logic       regWriteE;
    logic       loadE;
    logic       hiloReadE;
    logic [4:0] writeRegM;
    logic       regWriteM;
    logic [1:0] loadTypeM;
    logic       hiloReadM;
    logic [4:0] writeRegW;
    logic       regWriteW;
    logic       hiloReadW;
    logic       multD;
    logic       divD;
    logic       hiloReadD;
    logic [2:0] forwardAD;
    logic [2:0] forwardBD;
    logic       stallF;
    logic       stallD;
    logic       flushE;
    logic       muldivStartE;
    logic       hiloWe;
    logic       muldivBusy;

    int vectorCount = 0;
    int missCount   = 0;

    hazard_ctrl #(
        .MULT_CYCLES (4),
        .DIV_CYCLES  (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rsD          (rsD),
        .rtD          (rtD),
        .useRsD       (useRsD),
        .useRtD       (useRtD),
        .writeRegE    (writeRegE),
        .regWriteE    (regWriteE),
        .loadE        (loadE),
        .hiloReadE    (hiloReadE),
        .writeRegM    (writeRegM),
        .regWriteM    (regWriteM),
        .loadTypeM    (loadTypeM),
        .hiloReadM    (hiloReadM),
        .writeRegW    (writeRegW),
        .regWriteW    (regWriteW),
        .hiloReadW    (hiloReadW),
        .multD        (multD),
        .divD         (divD),
        .hiloReadD    (hiloReadD),
        .forwardAD    (forwardAD),
        .forwardBD    (forwardBD),
        .stallF       (stallF),
        .stallD       (stallD),
        .flushE       (flushE),
        .muldivStartE (muldivStartE),
        .hiloWe       (hiloWe),
        .muldivBusy   (muldivBusy)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach the end in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Move to the next falling edge and return every pipeline input to a bubble.
    task automatic applyStimulus();
        @(negedge clk);
        rsD = 5'd0;  rtD = 5'd0;  useRsD = 1'b0;  useRtD = 1'b0;
        writeRegE = 5'd0;  regWriteE = 1'b0;  loadE = 1'b0;  hiloReadE = 1'b0;
        writeRegM = 5'd0;  regWriteM = 1'b0;  loadTypeM = 2'd0;  hiloReadM = 1'b0;
        writeRegW = 5'd0;  regWriteW = 1'b0;  hiloReadW = 1'b0;
        multD = 1'b0;  divD = 1'b0;  hiloReadD = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkStall(input string tag, input logic expected);
        checkOutput({tag, "_stallF"}, 32'(stallF), 32'(expected));
        checkOutput({tag, "_stallD"}, 32'(stallD), 32'(expected));
        checkOutput({tag, "_flushE"}, 32'(flushE), 32'(expected));
    endtask

    task automatic checkMuldiv(input string tag, input logic expStart, input logic expBusy,
                               input logic expWe, input logic expStall);
        checkOutput({tag, "_start"}, 32'(muldivStartE), 32'(expStart));
        checkOutput({tag, "_busy"},  32'(muldivBusy),   32'(expBusy));
        checkOutput({tag, "_hiloWe"}, 32'(hiloWe),      32'(expWe));
        checkOutput({tag, "_stallD"}, 32'(stallD),      32'(expStall));
    endtask

    initial begin
        rst = 1'b1;

        // Reset: stimulus that would forward, stall and launch must all read as zero.
        for (int i = 0; i < 2; i++) begin
            applyStimulus();
            rsD = 5'd3;  useRsD = 1'b1;  rtD = 5'd3;  useRtD = 1'b1;
            writeRegE = 5'd3;  regWriteE = 1'b1;  loadE = 1'b1;
            writeRegM = 5'd3;  regWriteM = 1'b1;  multD = 1'b1;
            #1;
            checkOutput("rst_fwdA", 32'(forwardAD), 32'd0);
            checkOutput("rst_fwdB", 32'(forwardBD), 32'd0);
            checkStall("rst", 1'b0);
            checkMuldiv("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        applyStimulus();
        rst = 1'b0;
        #1;
        checkMuldiv("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // rs forwarding from E, M and W.
        applyStimulus();
        rsD = 5'd5;  useRsD = 1'b1;  writeRegE = 5'd5;  regWriteE = 1'b1;
        #1;
        checkOutput("fwdA_E", 32'(forwardAD), 32'd1);
        checkStall("fwdA_E", 1'b0);

        applyStimulus();
        rsD = 5'd5;  useRsD = 1'b1;  writeRegM = 5'd5;  regWriteM = 1'b1;
        #1;
        checkOutput("fwdA_M", 32'(forwardAD), 32'd2);

        applyStimulus();
        rsD = 5'd5;  useRsD = 1'b1;  writeRegW = 5'd5;  regWriteW = 1'b1;  hiloReadW = 1'b1;
        #1;
        checkOutput("fwdA_Whilo", 32'(forwardAD), 32'd6);

        applyStimulus();
        rsD = 5'd5;  useRsD = 1'b1;  writeRegW = 5'd5;  regWriteW = 1'b1;
        #1;
        checkOutput("fwdA_Wplain", 32'(forwardAD), 32'd0);

        applyStimulus();
        rsD = 5'd5;  useRsD = 1'b1;  writeRegM = 5'd5;  regWriteM = 1'b1;  hiloReadM = 1'b1;
        #1;
        checkOutput("fwdA_Mhilo", 32'(forwardAD), 32'd7);

        applyStimulus();
        rsD = 5'd5;  useRsD = 1'b0;  writeRegE = 5'd5;  regWriteE = 1'b1;
        #1;
        checkOutput("fwdA_unused", 32'(forwardAD), 32'd0);

        // rt forwarding: M load widths and E priority over M.
        applyStimulus();
        rtD = 5'd8;  useRtD = 1'b1;  writeRegM = 5'd8;  regWriteM = 1'b1;  loadTypeM = 2'd2;
        #1;
        checkOutput("fwdB_lh", 32'(forwardBD), 32'd4);
        checkOutput("fwdB_lh_A", 32'(forwardAD), 32'd0);

        applyStimulus();
        rtD = 5'd8;  useRtD = 1'b1;  writeRegM = 5'd8;  regWriteM = 1'b1;  loadTypeM = 2'd3;
        #1;
        checkOutput("fwdB_lb", 32'(forwardBD), 32'd5);

        applyStimulus();
        rtD = 5'd8;  useRtD = 1'b1;  writeRegM = 5'd8;  regWriteM = 1'b1;  loadTypeM = 2'd3;
        writeRegE = 5'd8;  regWriteE = 1'b1;
        #1;
        checkOutput("fwdB_Ewins", 32'(forwardBD), 32'd1);

        applyStimulus();
        rtD = 5'd8;  useRtD = 1'b1;  writeRegM = 5'd8;  regWriteM = 1'b1;  loadTypeM = 2'd2;
        writeRegE = 5'd8;  regWriteE = 1'b1;  loadE = 1'b1;
        #1;
        checkOutput("fwdB_Eload", 32'(forwardBD), 32'd4);
        checkStall("fwdB_Eload", 1'b1);

        // Register 0 never forwards nor stalls.
        applyStimulus();
        rsD = 5'd0;  useRsD = 1'b1;
        writeRegE = 5'd0;  regWriteE = 1'b1;  loadE = 1'b1;
        writeRegM = 5'd0;  regWriteM = 1'b1;
        writeRegW = 5'd0;  regWriteW = 1'b1;  hiloReadW = 1'b1;
        #1;
        checkOutput("r0_fwdA", 32'(forwardAD), 32'd0);
        checkStall("r0", 1'b0);

        // Load-use: stall for one cycle, then forward the word from M.
        applyStimulus();
        rsD = 5'd3;  useRsD = 1'b1;  writeRegE = 5'd3;  regWriteE = 1'b1;  loadE = 1'b1;
        #1;
        checkStall("lw_use", 1'b1);

        applyStimulus();
        rsD = 5'd3;  useRsD = 1'b1;  writeRegM = 5'd3;  regWriteM = 1'b1;  loadTypeM = 2'd1;
        #1;
        checkOutput("lw_after_fwdA", 32'(forwardAD), 32'd3);
        checkStall("lw_after", 1'b0);

        // mfhi in E feeding rt also stalls; a non-writing load does not.
        applyStimulus();
        rtD = 5'd9;  useRtD = 1'b1;  writeRegE = 5'd9;  regWriteE = 1'b1;  hiloReadE = 1'b1;
        #1;
        checkStall("mfhi_use", 1'b1);

        applyStimulus();
        rtD = 5'd9;  useRtD = 1'b1;  writeRegE = 5'd9;  regWriteE = 1'b0;  loadE = 1'b1;
        #1;
        checkStall("nowrite_load", 1'b0);

        // A load-use stall suppresses the mult launch.
        applyStimulus();
        rsD = 5'd3;  useRsD = 1'b1;  writeRegE = 5'd3;  regWriteE = 1'b1;  loadE = 1'b1;
        multD = 1'b1;
        #1;
        checkMuldiv("mult_lu", 1'b0, 1'b0, 1'b0, 1'b1);

        applyStimulus();
        #1;
        checkMuldiv("mult_lu_after", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef HAZ_MULDIV_ITER_EN
        // Mult at t, mfhi waiting in D from t+1.
        applyStimulus();
        multD = 1'b1;
        #1;
        checkMuldiv("mult_t0", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus();
            hiloReadD = 1'b1;
            #1;
            checkMuldiv($sformatf("mult_t%0d", k), 1'b0, k <= 5, k == 5, k <= 5);
        end

        // Back-to-back mult: the second waits until IDLE, then launches.
        applyStimulus();
        multD = 1'b1;
        #1;
        checkMuldiv("b2b_t0", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus();
            multD = 1'b1;
            #1;
            checkMuldiv($sformatf("b2b_t%0d", k), k == 6, k <= 5, k == 5, k <= 5);
        end
        for (int k = 7; k <= 12; k++) begin
            applyStimulus();
            #1;
            checkMuldiv($sformatf("b2b_t%0d", k), 1'b0, k <= 11, k == 11, 1'b0);
        end

        // Full-length divide.
        applyStimulus();
        divD = 1'b1;
        #1;
        checkMuldiv("div_t0", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 34; k++) begin
            applyStimulus();
            #1;
            checkMuldiv($sformatf("div_t%0d", k), 1'b0, k <= 33, k == 33, 1'b0);
        end

        // Divide aborted by reset at t+10; a following mult launches at once.
        applyStimulus();
        divD = 1'b1;
        #1;
        checkMuldiv("divrst_t0", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus();
            #1;
            checkMuldiv($sformatf("divrst_t%0d", k), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus();
        rst = 1'b1;
        hiloReadD = 1'b1;  rsD = 5'd3;  useRsD = 1'b1;  writeRegE = 5'd3;  regWriteE = 1'b1;
        #1;
        checkOutput("divrst_t10_fwdA", 32'(forwardAD), 32'd0);
        checkStall("divrst_t10", 1'b0);
        checkMuldiv("divrst_t10", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        rst = 1'b0;
        multD = 1'b1;
        #1;
        checkMuldiv("divrst_t11", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 12; k <= 42; k++) begin
            applyStimulus();
            #1;
            checkMuldiv($sformatf("divrst_t%0d", k), 1'b0, k <= 16, k == 16, 1'b0);
        end
`else
        // Single-cycle mult: HI/LO written the next cycle, no busy stall.
        applyStimulus();
        multD = 1'b1;
        #1;
        checkMuldiv("mult_t0", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        hiloReadD = 1'b1;
        #1;
        checkMuldiv("mult_t1", 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus();
        hiloReadD = 1'b1;
        #1;
        checkMuldiv("mult_t2", 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back launches each write HI/LO a cycle later.
        applyStimulus();
        multD = 1'b1;
        #1;
        checkMuldiv("b2b_t0", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        divD = 1'b1;
        #1;
        checkMuldiv("b2b_t1", 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus();
        #1;
        checkMuldiv("b2b_t2", 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus();
        #1;
        checkMuldiv("b2b_t3", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset right after a launch discards the pending HI/LO write.
        applyStimulus();
        divD = 1'b1;
        #1;
        checkMuldiv("divrst_t0", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        rst = 1'b1;
        multD = 1'b1;
        #1;
        checkMuldiv("divrst_t1", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        rst = 1'b0;
        #1;
        checkMuldiv("divrst_t2", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        multD = 1'b1;
        #1;
        checkMuldiv("divrst_t3", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        #1;
        checkMuldiv("divrst_t4", 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. Generates the 3-bit operand-forwarding selects for the decode-stage A/B forwarding muxes and produces the stall and flush controls for load-use hazards. Also sequences the multi-cycle multiply/divide unit, stalling decode while HI/LO is busy. Sits beside the datapath and is driven by register numbers and control bits from the D, E, M and W stages.

## Interface
- `MULT_CYCLES`, default 4: cycles a mult/multu occupies the HI/LO unit.
- `DIV_CYCLES`, default 32: cycles a div/divu occupies the HI/LO unit.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rsD`, `rtD` in 5 each: source registers of the instruction in D.
- `useRsD`, `useRtD` in 1 each: the instruction in D reads rs/rt.
- `writeRegE`, `regWriteE` in 5/1: destination register and write enable in E.
- `loadE`, `hiloReadE` in 1 each: E holds a load / an mfhi-mflo.
- `writeRegM`, `regWriteM` in 5/1: destination register and write enable in M.
- `loadTypeM` in 2: 0 = ALU, 1 = word, 2 = half, 3 = byte.
- `hiloReadM` in 1: M holds mfhi/mflo.
- `writeRegW`, `regWriteW`, `hiloReadW` in 5/1/1: W-stage destination, write enable and mfhi/mflo flag.
- `multD`, `divD`, `hiloReadD` in 1 each: D holds mult*, div* or mfhi/mflo.
- `forwardAD`, `forwardBD` out 3 each: mux selects.
- `stallF`, `stallD`, `flushE` out 1 each.
- `muldivStartE` out 1: launch pulse to the mult/div unit.
- `hiloWe` out 1: HI/LO write-enable pulse.
- `muldivBusy` out 1: registered busy flag.

## Operation
- **Forward select per operand.** The rule is evaluated for rs→`forwardAD` and rt→`forwardBD`. Priority is E > M > W > register file.
  - Register 0, or operand not used → 0.
  - E match (`regWriteE`, not load, not hiloRead) → 1 (aluoutE).
  - M match with `hiloReadM` → 7. M match with `loadTypeM` = 3/2/1 → 5/4/3. M match otherwise → 2.
  - W match with `hiloReadW` → 6.
  - Otherwise → 0.
- **Load-use stall.** A used operand matches `writeRegE` (nonzero, `regWriteE`) while `loadE` or `hiloReadE` is set → `stallF` = `stallD` = `flushE` = 1.
- **Mult/div FSM states.**
  - IDLE: `muldivBusy` = 0.
  - BUSY: a counter counts down from N−1 to 0, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - DONE: a single cycle in which `hiloWe` = 1; then returns to IDLE.
- **Launch.** In IDLE, (`multD` | `divD`) with D not stalled → `muldivStartE` = 1 that cycle, then BUSY next cycle.
- **Busy stall.** In BUSY or DONE, (`hiloReadD` | `multD` | `divD`) → stall F/D and flush E.
- **Simultaneous conditions.** Load-use and busy stall combine by OR. `muldivStartE` is suppressed whenever stallD = 1.
- **Reset.** While `rst` = 1, every output is 0. The FSM goes to IDLE and the counter clears, including mid-operation; the in-flight mult/div is discarded with no `hiloWe`.

## Timing
- Forward selects, stalls, flushE and `muldivStartE` are combinational from the inputs and registered state; there are no added cycles.
- `muldivBusy` rises the cycle after `muldivStartE`.
- Mult launched at cycle t:
  - BUSY for cycles t+1 .. t+N.
  - `hiloWe` at t+N+1.
  - mfhi waiting in D is released at t+N+2.
- Back-to-back mult: the second one stalls until the FSM returns to IDLE, then launches that cycle.

## Configuration
- `HAZ_MULDIV_ITER_EN` defined: the iterative mult/div sequencing above is compiled in.
- Not defined:
  - The FSM is removed; mult/div are single-cycle.
  - `muldivBusy` = 0.
  - `hiloWe` is driven from the registered `muldivStartE` one cycle later.
  - No busy stalls.
  - The `MULT_CYCLES`/`DIV_CYCLES` parameters are ignored.

## Structure
- Shared package holds:
  - forward-select constants (`FWD_REG`=0, `FWD_ALUE`=1, `FWD_ALUM`=2, `FWD_WORDM`=3, `FWD_HALFM`=4, `FWD_BYTEM`=5, `FWD_HILOW`=6, `FWD_HILOM`=7);
  - the load-type encoding;
  - the FSM state encoding.
- One sub-module, `hazard_fwd_sel`: the combinational per-operand select, instantiated twice (rs, rt).

## Test plan
- rsD = 5, E: add writes r5 → `forwardAD` = 1. Same with M instead → 2. Same with W mfhi → 6.
- rtD = 8, M: lh to r8 → `forwardBD` = 4. lb → 5. E simultaneously writes r8 → 1 (E wins).
- rsD = 0 with every stage writing r0 → `forwardAD` = 0, no stall.
- E: lw r3, D uses r3 → `stallF`/`stallD`/`flushE` = 1 for one cycle. Next cycle `forwardAD` = 3, no stall.
- Mult at t, mfhi in D at t+1 (`MULT_CYCLES` = 4) → stalled t+1..t+5, `hiloWe` at t+5, mfhi proceeds t+6.
- Div launched, `rst` at t+10 → all outputs 0, IDLE, no `hiloWe`; a new mult after reset launches immediately.
